// File: rtl/onchip_ram_arb_pkg.sv
// Shared types for the on-chip RAM arbiter: quiesce states and port index.
package onchip_ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } arb_state_t;

  typedef logic port_idx_t;

  localparam port_idx_t PORT0 = 1'b0;
  localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/onchip_ram_arb_pick.sv
// Two-way request picker for the RAM arbiter.
// Build option: ONCHIP_RAM_ARB_FIXED_PRIO_EN makes port 0 win every tie;
// otherwise ties go to the port that was not granted last.
module onchip_ram_arb_pick
  import onchip_ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  rr_last,
  output logic       gnt_valid,
  output port_idx_t  gnt_idx
);

  // Single requester wins outright; ties resolved by priority mode.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT0;
    if (req == 2'b10) begin
      gnt_idx = PORT1;
    end else if (req == 2'b11) begin
`ifdef ONCHIP_RAM_ARB_FIXED_PRIO_EN
      gnt_idx = PORT0;
`else
      gnt_idx = (rr_last == PORT0) ? PORT1 : PORT0;
`endif
    end
  end

endmodule

// File: rtl/onchip_ram_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port on-chip RAM with
// a reset_req quiesce handshake (drain the in-flight read, then gate clken).
// Build option: ONCHIP_RAM_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | normal arbitration, one grant per cycle
//  ST_DRAIN | quiesce requested while a read was returning; no grants
//  ST_HALT  | quiesced: no grants, RAM clock gated, halted=1
module onchip_ram_arbiter
  import onchip_ram_arb_pkg::*;
#(
  parameter  int ADDR_W = 10,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              halted
);

  arb_state_t state, state_next;
  port_idx_t  rr_last, rd_port, gnt_idx;
  logic       rd_pend, gnt_valid, grant, rd_accept, sel_read, sel_write;
  logic [1:0] req;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  onchip_ram_arb_pick u_pick (
    .req       (req),
    .rr_last   (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // State register and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      rd_pend <= 1'b0;
      rd_port <= PORT0;
    end else begin
      state   <= state_next;
      rd_pend <= rd_accept;
      if (rd_accept) rd_port <= gnt_idx;
    end
  end

`ifdef ONCHIP_RAM_ARB_FIXED_PRIO_EN
  // Fixed priority has no fairness history.
  always_ff @(posedge clk) begin
    rr_last <= PORT1;
  end
`else
  // Remember the last granted port for the round-robin tie break.
  always_ff @(posedge clk) begin
    if (reset)      rr_last <= PORT1;
    else if (grant) rr_last <= gnt_idx;
  end
`endif

  // Grant, RAM mux, handshakes and next state.
  // DRAIN is entered when quiesce is requested in the cycle a read is being
  // returned, keeping the RAM clocked one extra cycle before gating it.
  always_comb begin
    grant     = gnt_valid && (state == ST_RUN) && !reset_req && !reset;
    sel_read  = (gnt_idx == PORT1) ? m1_read  : m0_read;
    sel_write = (gnt_idx == PORT1) ? m1_write : m0_write;
    rd_accept = grant && sel_read && !sel_write;

    ram_address    = (gnt_idx == PORT1) ? m1_address    : m0_address;
    ram_byteenable = (gnt_idx == PORT1) ? m1_byteenable : m0_byteenable;
    ram_writedata  = (gnt_idx == PORT1) ? m1_writedata  : m0_writedata;
    ram_chipselect = grant;
    ram_write      = grant && sel_write;

    m0_waitrequest = !(grant && (gnt_idx == PORT0));
    m1_waitrequest = !(grant && (gnt_idx == PORT1));

    m0_readdata      = ram_readdata;
    m1_readdata      = ram_readdata;
    m0_readdatavalid = rd_pend && !reset && (rd_port == PORT0);
    m1_readdatavalid = rd_pend && !reset && (rd_port == PORT1);

    ram_clken = reset || (state != ST_HALT);
    halted    = (state == ST_HALT);

    state_next = state;
    case (state)
      ST_RUN:   if (reset_req) state_next = rd_pend ? ST_DRAIN : ST_HALT;
      ST_DRAIN: state_next = ST_HALT;
      ST_HALT:  if (!reset_req) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Self-checking bench for onchip_ram_arbiter: behavioural RAM, abstract
// arbitration model, and a read-response scoreboard checked by a monitor.
module tb_onchip_ram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
`ifdef ONCHIP_RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, reset_req;
  logic [ADDR_W-1:0] m0_address, m1_address, ram_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, ram_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, ram_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, ram_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              ram_chipselect, ram_write, ram_clken, halted;

  always #5 clk = ~clk;

  onchip_ram_arbiter dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata), .halted(halted)
  );

  // Behavioural single-port RAM: registered q, byte-lane writes.
  logic [31:0] ram_mem [1024];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
      else           ram_readdata <= ram_mem[ram_address];
    end
  end

  // Reference model state.
  typedef struct {
    bit          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic [31:0] shadow [1024];
  exp_t        expq[$];
  exp_t        mon_e;
  int          phase;        // 0 running, 1 draining, 2 halted
  int          last_port;
  int          last_rd_cyc;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  bit          p_vld [2];
  bit          p_wr [2];
  bit          p_rd_too [2];
  logic [9:0]  p_addr [2];
  logic [3:0]  p_be [2];
  logic [31:0] p_data [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_b(string name, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_w(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every read-data return must match the oldest expected response.
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (m0_readdatavalid && m1_readdatavalid) begin
        chk_b("dual_rdvalid", 1'b1, 1'b0);
      end else if (expq.size() == 0) begin
        chk_b("unexpected_rdvalid", 1'b1, 1'b0);
      end else begin
        mon_e = expq.pop_front();
        chk_b("rd_port", m1_readdatavalid, mon_e.port);
        chk_w("rd_data", m1_readdatavalid ? m1_readdata : m0_readdata, mon_e.data);
        chk_w("rd_cycle", cyc, mon_e.due);
      end
    end else if (expq.size() != 0 && expq[0].due <= cyc) begin
      chk_b("missing_rdvalid", 1'b0, 1'b1);
      mon_e = expq.pop_front();
    end
  end

  task automatic set_reset(bit v);
    reset = v;
    if (v) expq.delete();
  endtask

  task automatic cmd(int p, bit wr, logic [9:0] a, logic [3:0] be, logic [31:0] d);
    p_vld[p] = 1'b1; p_wr[p] = wr; p_rd_too[p] = 1'b0;
    p_addr[p] = a; p_be[p] = be; p_data[p] = d;
  endtask

  // One clock: drive pending commands, predict and check, advance the model.
  task automatic step();
    int g;
    logic [31:0] mask;
    m0_address = p_addr[0]; m0_byteenable = p_be[0]; m0_writedata = p_data[0];
    m0_write = p_vld[0] & p_wr[0]; m0_read = p_vld[0] & (~p_wr[0] | p_rd_too[0]);
    m1_address = p_addr[1]; m1_byteenable = p_be[1]; m1_writedata = p_data[1];
    m1_write = p_vld[1] & p_wr[1]; m1_read = p_vld[1] & (~p_wr[1] | p_rd_too[1]);
    @(negedge clk);
    g = -1;
    if (reset) begin
      chk_b("rst_wait0", m0_waitrequest, 1'b1);
      chk_b("rst_wait1", m1_waitrequest, 1'b1);
      chk_b("rst_cs", ram_chipselect, 1'b0);
      chk_b("rst_clken", ram_clken, 1'b1);
    end else begin
      if (phase == 0 && !reset_req) begin
        if (p_vld[0] && p_vld[1]) g = (FIXED || last_port == 1) ? 0 : 1;
        else if (p_vld[0])        g = 0;
        else if (p_vld[1])        g = 1;
      end
      chk_b("wait0", m0_waitrequest, g != 0);
      chk_b("wait1", m1_waitrequest, g != 1);
      chk_b("ram_cs", ram_chipselect, g >= 0);
      chk_b("clken", ram_clken, phase != 2);
      chk_b("halted", halted, phase == 2);
      case (phase)
        0: if (reset_req) phase = (last_rd_cyc == cyc - 1) ? 1 : 2;
        1: phase = 2;
        default: if (!reset_req) phase = 0;
      endcase
      if (g >= 0) begin
        chk_w("ram_addr", 32'(ram_address), 32'(p_addr[g]));
        chk_b("ram_write", ram_write, p_wr[g]);
        if (p_wr[g]) begin
          chk_w("ram_wdata", ram_writedata, p_data[g]);
          chk_w("ram_be", 32'(ram_byteenable), 32'(p_be[g]));
          mask = {{8{p_be[g][3]}}, {8{p_be[g][2]}}, {8{p_be[g][1]}}, {8{p_be[g][0]}}};
          shadow[p_addr[g]] = (shadow[p_addr[g]] & ~mask) | (p_data[g] & mask);
        end else begin
          expq.push_back('{port: (g == 1), data: shadow[p_addr[g]], due: cyc + 1});
          last_rd_cyc = cyc;
        end
        last_port = g;
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      phase = 0; last_port = 1; last_rd_cyc = -10;
    end
    if (g >= 0) p_vld[g] = 1'b0;
  endtask

  task automatic new_cmd(int p);
    cmd(p, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 4'($urandom), $urandom);
    p_rd_too[p] = p_wr[p] && ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 32'(i) * 32'h0001_0001 ^ 32'hC3C3_0000;
      shadow[i]  = 32'(i) * 32'h0001_0001 ^ 32'hC3C3_0000;
    end
    ram_mem[5] = 32'hDEAD_BEEF;
    shadow[5]  = 32'hDEAD_BEEF;
    for (int p = 0; p < 2; p++) begin
      p_vld[p] = 1'b0; p_wr[p] = 1'b0; p_rd_too[p] = 1'b0;
      p_addr[p] = '0; p_be[p] = '0; p_data[p] = '0;
    end
    phase = 0; last_port = 1; last_rd_cyc = -10;
    reset_req = 1'b0;
    set_reset(1'b1);
    repeat (3) step();
    set_reset(1'b0);

    // Single read of the preloaded word.
    cmd(0, 1'b0, 10'h005, 4'hF, 32'h0);
    repeat (3) step();

    // Both ports reading every cycle from a fresh reset.
    set_reset(1'b1); step(); set_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++) if (!p_vld[p]) cmd(p, 1'b0, 10'($urandom_range(0, 1023)), 4'hF, 32'h0);
      step();
    end
    p_vld[0] = 1'b0; p_vld[1] = 1'b0;
    repeat (2) step();

    // Partial write from port 1, read back from port 0.
    cmd(1, 1'b1, 10'h3FF, 4'b0011, 32'h1234_5678);
    step();
    cmd(0, 1'b0, 10'h3FF, 4'hF, 32'h0);
    repeat (2) step();

    // Quiesce right after a read; port 1 waits through DRAIN/HALT.
    cmd(0, 1'b0, 10'h007, 4'hF, 32'h0);
    step();
    reset_req = 1'b1;
    cmd(1, 1'b0, 10'h009, 4'hF, 32'h0);
    repeat (4) step();
    reset_req = 1'b0;
    repeat (3) step();

    // Reset lands on the edge right after a read is accepted.
    cmd(0, 1'b0, 10'h00C, 4'hF, 32'h0);
    step();
    set_reset(1'b1);
    repeat (2) step();
    set_reset(1'b0);
    repeat (2) step();

    // Continuous contention for six cycles.
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < 2; p++) if (!p_vld[p]) cmd(p, 1'b0, 10'($urandom_range(0, 1023)), 4'hF, 32'h0);
      step();
    end
    p_vld[0] = 1'b0; p_vld[1] = 1'b0;
    repeat (2) step();

    // Randomized traffic with quiesce requests and occasional resets.
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) if (!p_vld[p] && $urandom_range(0, 2) != 0) new_cmd(p);
      if (!reset_req && $urandom_range(0, 40) == 0)   reset_req = 1'b1;
      else if (reset_req && $urandom_range(0, 3) == 0) reset_req = 1'b0;
      if (!reset && $urandom_range(0, 150) == 0) set_reset(1'b1);
      else if (reset)                            set_reset(1'b0);
      step();
    end

    reset_req = 1'b0;
    set_reset(1'b0);
    repeat (20) step();
    chk_w("exp_queue_empty", expq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
